// File: rtl/fifo8_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fifo8_pkg
// Desc     : Shared sizing constants and state encodings for the 8-entry
//            FIFO control slice (fifo8_ctrl, fifo8_side_ctrl).
// Revision : 1.0 - initial release
// ============================================================================
package fifo8_pkg;

  // Storage geometry: depth must match the storage array it drives.
  localparam int c_DEPTH = 8;
  localparam int c_CNT_W = 4;

  // Default almost-full / almost-empty thresholds.
  localparam int c_AF_LEVEL = 6;
  localparam int c_AE_LEVEL = 2;

  // Global controller state.
  typedef enum logic [0:0] {
    G_INIT = 1'b0,
    G_RUN  = 1'b1
  } gstate_t;

  // Write-side view of a pointer engine.
  typedef enum logic [0:0] {
    W_RUN  = 1'b0,
    W_WRAP = 1'b1
  } wstate_t;

  // Read-side view of a pointer engine.
  typedef enum logic [0:0] {
    R_RUN  = 1'b0,
    R_WRAP = 1'b1
  } rstate_t;

  // Generic encoding used inside the shared side engine; matches both views.
  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_WRAP = 1'b1
  } side_state_t;

endpackage : fifo8_pkg
`default_nettype wire

// File: rtl/fifo8_side_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo8_side_ctrl
// Desc     : One pointer side (write or read) of the FIFO controller: a
//            shadow pointer plus a RUN/WRAP FSM. After an operation at the
//            last slot the side spends one cycle in WRAP, during which the
//            storage pointer is cleared and no operation is allowed.
// Revision : 1.0 - initial release
// ============================================================================
module fifo8_side_ctrl
  import fifo8_pkg::*;
#(
  parameter int DEPTH = c_DEPTH,
  parameter int PTR_W = $clog2(c_DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,     // global INIT or flush: return to RUN at slot 0
  input  logic i_op_ok,   // everything outside this side permits an operation
  input  logic i_req,     // requester wants an operation this cycle
  output logic o_ready,   // operation would be accepted if requested
  output logic o_fire,    // operation accepted this cycle
  output logic o_wrap     // WRAP cycle: storage pointer clear
);

  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);

  side_state_t      r_state;
  logic [PTR_W-1:0] r_ptr;

  assign o_ready = (r_state == S_RUN) && i_op_ok;
  assign o_fire  = o_ready && i_req;
  assign o_wrap  = (r_state == S_WRAP);

  // Shadow pointer and RUN/WRAP sequencing.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_state <= S_RUN;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (o_fire) begin
            if (r_ptr == c_LAST) begin
              // Hold at the last slot; the WRAP cycle zeroes it.
              r_state <= S_WRAP;
            end else begin
              r_ptr <= r_ptr + PTR_W'(1);
            end
          end
        end
        S_WRAP: begin
          r_state <= S_RUN;
          r_ptr   <= '0;
        end
        default: begin
          r_state <= S_RUN;
          r_ptr   <= '0;
        end
      endcase
    end
  end

endmodule : fifo8_side_ctrl
`default_nettype wire

// File: rtl/fifo8_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo8_ctrl
// Desc     : Handshake-to-strobe controller for an 8 x 9 FIFO storage block.
//            Generates write/read enables, pointer increments and pointer
//            clears, inserts one-cycle wrap clears for the storage's linear
//            pointers, and tracks occupancy with registered flags.
// Options  : FIFO8_CTRL_ALMOST_EN adds registered almost_full/almost_empty.
// Revision : 1.0 - initial release
// ============================================================================
module fifo8_ctrl
  import fifo8_pkg::*;
#(
  parameter int DEPTH = c_DEPTH,
  parameter int CNT_W = c_CNT_W
`ifdef FIFO8_CTRL_ALMOST_EN
  ,
  parameter int AF_LEVEL = c_AF_LEVEL,
  parameter int AE_LEVEL = c_AE_LEVEL
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             pop_req,
  input  logic             flush,
  output logic             wren,
  output logic             WrInc,
  output logic             rden,
  output logic             RdInc,
  output logic             WrPtrClr,
  output logic             RdPtrClr,
  output logic             rd_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef FIFO8_CTRL_ALMOST_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

  gstate_t          r_gstate;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_rd_valid;

  logic             w_init;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_side_clr;
  logic             w_wr_ready;
  logic             w_wr_fire;
  logic             w_wr_wrap;
  logic             w_rd_ready;
  logic             w_rd_fire;
  logic             w_rd_wrap;
  wstate_t          w_wstate;
  rstate_t          w_rstate;
  logic [CNT_W-1:0] w_count_nxt;

  // Reset is treated as INIT so outputs are defined while rst is held.
  assign w_init     = rst || (r_gstate == G_INIT);
  assign w_wr_ok    = !w_init && !r_full  && !flush;
  assign w_rd_ok    = !w_init && !r_empty && !flush;
  assign w_side_clr = w_init || flush;

  fifo8_side_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W ($clog2(DEPTH))
  ) u_wr_side (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_side_clr),
    .i_op_ok (w_wr_ok),
    .i_req   (push_valid),
    .o_ready (w_wr_ready),
    .o_fire  (w_wr_fire),
    .o_wrap  (w_wr_wrap)
  );

  fifo8_side_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W ($clog2(DEPTH))
  ) u_rd_side (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_side_clr),
    .i_op_ok (w_rd_ok),
    .i_req   (pop_req),
    .o_ready (w_rd_ready),
    .o_fire  (w_rd_fire),
    .o_wrap  (w_rd_wrap)
  );

  assign w_wstate = w_wr_wrap ? W_WRAP : W_RUN;
  assign w_rstate = w_rd_wrap ? R_WRAP : R_RUN;

  // Storage strobes. Ready already excludes WRAP, so an enable can never
  // coincide with its own side's pointer clear.
  assign push_ready = w_wr_ready;
  assign wren       = w_wr_fire;
  assign WrInc      = w_wr_fire;
  assign rden       = w_rd_fire && (w_rstate == R_RUN);
  assign RdInc      = rden;
  assign WrPtrClr   = w_init || (w_wstate == W_WRAP);
  assign RdPtrClr   = w_init || (w_rstate == R_WRAP);

  assign rd_valid = r_rd_valid;
  assign count    = r_count;
  assign full     = r_full;
  assign empty    = r_empty;

  // Next occupancy: cleared by INIT/flush, otherwise +1/-1/hold.
  always_comb begin
    w_count_nxt = r_count;
    if (w_init || flush) begin
      w_count_nxt = '0;
    end else if (w_wr_fire && !rden) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (rden && !w_wr_fire) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Global FSM: INIT lasts one cycle after reset or flush, then RUN.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_gstate <= G_INIT;
    end else begin
      case (r_gstate)
        G_INIT:  r_gstate <= G_RUN;
        G_RUN:   r_gstate <= G_RUN;
        default: r_gstate <= G_INIT;
      endcase
    end
  end

  // Registered occupancy and full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Read data is valid the cycle after an accepted pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rden;
    end
  end

`ifdef FIFO8_CTRL_ALMOST_EN
  localparam logic [CNT_W-1:0] c_AF_CNT = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] c_AE_CNT = CNT_W'(AE_LEVEL);

  logic r_almost_full;
  logic r_almost_empty;

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;

  // Threshold flags track the same next-count as full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_nxt >= c_AF_CNT);
      r_almost_empty <= (w_count_nxt <= c_AE_CNT);
    end
  end
`endif

endmodule : fifo8_ctrl
`default_nettype wire

// File: tb/tb_fifo8_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo8_ctrl
// Desc     : Self-checking bench for fifo8_ctrl with an attached behavioural
//            8 x 9 storage array driven by the controller's strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo8_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_valid = 1'b0;
  logic       pop_req = 1'b0;
  logic       flush = 1'b0;
  logic       push_ready, wren, WrInc, rden, RdInc, WrPtrClr, RdPtrClr, rd_valid;
  logic [3:0] count;
  logic       full, empty;
`ifdef FIFO8_CTRL_ALMOST_EN
  logic       almost_full, almost_empty;
`endif

  always #5 clk = ~clk;

  fifo8_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .pop_req    (pop_req),
    .flush      (flush),
    .wren       (wren),
    .WrInc      (WrInc),
    .rden       (rden),
    .RdInc      (RdInc),
    .WrPtrClr   (WrPtrClr),
    .RdPtrClr   (RdPtrClr),
    .rd_valid   (rd_valid),
    .count      (count),
    .full       (full),
    .empty      (empty)
`ifdef FIFO8_CTRL_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // Linear-pointer storage as it would sit downstream of the controller.
  logic [8:0] din = 9'd0;
  logic [8:0] mem [0:7];
  logic [3:0] s_wp = 4'd0;
  logic [3:0] s_rp = 4'd0;
  logic [8:0] s_dout = 9'd0;

  always @(posedge clk) begin
    if (WrPtrClr) s_wp <= 4'd0;
    else if (WrInc) begin
      if (wren && s_wp < 4'd8) mem[s_wp[2:0]] <= din;
      s_wp <= s_wp + 4'd1;
    end
    if (RdPtrClr) s_rp <= 4'd0;
    else if (RdInc) begin
      if (rden && s_rp < 4'd8) s_dout <= mem[s_rp[2:0]];
      s_rp <= s_rp + 4'd1;
    end
  end

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  typedef struct {
    logic [8:0] data;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: FIFO contents as a queue, plus per-side write/read
  // counts since the last pointer clear and a pending wrap bubble.
  logic [8:0] m_q[$];
  bit         m_init  = 1'b1;
  int         m_wn    = 0;
  int         m_rn    = 0;
  bit         m_wwrap = 1'b0;
  bit         m_rwrap = 1'b0;
  logic [8:0] m_din   = 9'd1;
  int         n_wr    = 0;
  int         n_rd    = 0;

  initial forever begin
    @(posedge clk);
    ncyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, ncyc);
    end
  endtask

  // One clock of stimulus, model prediction and comparison.
  task automatic step(input bit r, input bit pv, input bit pr, input bit fl);
    bit run, e_pr, e_wr, e_rd, e_wclr, e_rclr;
    int sz;
    exp_t it;
    @(negedge clk);
    rst = r; push_valid = pv; pop_req = pr; flush = fl; din = m_din;
    #1;
    sz     = m_q.size();
    run    = !r && !m_init;
    e_pr   = run && !m_wwrap && (sz < 8) && !fl;
    e_wr   = e_pr && pv;
    e_rd   = run && !m_rwrap && (sz > 0) && !fl && pr;
    e_wclr = r || m_init || m_wwrap;
    e_rclr = r || m_init || m_rwrap;
    chk("push_ready", push_ready, e_pr);
    chk("wren", wren, e_wr);
    chk("WrInc", WrInc, e_wr);
    chk("rden", rden, e_rd);
    chk("RdInc", RdInc, e_rd);
    chk("WrPtrClr", WrPtrClr, e_wclr);
    chk("RdPtrClr", RdPtrClr, e_rclr);
    chk("count", count, sz);
    chk("full", full, sz == 8);
    chk("empty", empty, sz == 0);
`ifdef FIFO8_CTRL_ALMOST_EN
    chk("almost_full", almost_full, sz >= 6);
    chk("almost_empty", almost_empty, sz <= 2);
`endif
    if (e_wr) begin
      chk("storage_wp_range", s_wp < 4'd8, 1'b1);
      n_wr++;
    end
    if (e_rd) begin
      chk("storage_rp_range", s_rp < 4'd8, 1'b1);
      n_rd++;
      it.data = m_q.pop_front();
      it.cyc  = ncyc;
      exp_q.push_back(it);
    end
    if (e_wr) begin
      m_q.push_back(m_din);
      m_din = m_din + 9'd1;
    end
    if (r || fl || m_init) begin
      m_init = r || fl;
      m_q.delete();
      m_wn = 0; m_rn = 0; m_wwrap = 0; m_rwrap = 0;
    end else begin
      if (m_wwrap) m_wwrap = 0;
      else if (e_wr) begin
        if (m_wn == 7) begin m_wwrap = 1; m_wn = 0; end
        else m_wn++;
      end
      if (m_rwrap) m_rwrap = 0;
      else if (e_rd) begin
        if (m_rn == 7) begin m_rwrap = 1; m_rn = 0; end
        else m_rn++;
      end
    end
  endtask

  // Monitor: every rd_valid must match the oldest outstanding pop.
  initial forever begin
    exp_t it;
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].cyc + 1 < ncyc) begin
      it = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL rd_valid_missing got none expected data %0h from cycle %0d", it.data, it.cyc);
    end
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_valid_unexpected got 1 expected 0 at cycle %0d", ncyc);
      end else begin
        it = exp_q.pop_front();
        if (s_dout !== it.data || it.cyc + 1 != ncyc) begin
          errors++;
          $display("FAIL rd_data got %0h expected %0h (pop cycle %0d, now %0d)",
                   s_dout, it.data, it.cyc, ncyc);
        end
      end
    end
  end

  initial begin
    // Reset held three cycles, then release.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("init_wrclr", WrPtrClr, 1'b1);
    step(0, 0, 0, 0);
    chk("run_push_ready", push_ready, 1'b1);

    // Fill: ten push cycles, eight accepted.
    n_wr = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    chk("fill_wren_pulses", n_wr, 8);
    step(0, 0, 0, 0);
    chk("fill_count", count, 4'd8);
    chk("fill_full", full, 1'b1);

    // Drain: ten pop cycles, eight accepted.
    n_rd = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    chk("drain_rden_pulses", n_rd, 8);
    step(0, 0, 0, 0);
    chk("drain_empty", empty, 1'b1);

    // Build to four, then sustained push+pop across wrap bubbles.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Flush to empty, fill to five, then flush at five.
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_flush_count", count, 4'd5);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("flush_wrclr", WrPtrClr, 1'b1);
    chk("flush_rdclr", RdPtrClr, 1'b1);
    chk("flush_count", count, 4'd0);
    step(0, 1, 0, 0);
    chk("post_flush_push", wren, 1'b1);
    chk("post_flush_slot0", s_wp, 4'd0);

    // Pop at empty with a simultaneous push: pop ignored.
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("empty_pop_ignored", rden, 1'b0);
    step(0, 0, 0, 0);
    chk("empty_pop_count", count, 4'd1);
    chk("empty_pop_no_valid", rd_valid, 1'b0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      bit pv, pr, fl, r;
      int phase;
      phase = (i / 60) % 3;
      pv = ($urandom_range(0, 9) < (phase == 0 ? 8 : (phase == 1 ? 3 : 6)));
      pr = ($urandom_range(0, 9) < (phase == 0 ? 3 : (phase == 1 ? 8 : 6)));
      fl = ($urandom_range(0, 79) == 0);
      r  = ($urandom_range(0, 199) == 0);
      step(r, pv, pr, fl);
    end

    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("outstanding_reads", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo8_ctrl
`default_nettype wire
